// File: rtl/ps2_decode_if.sv
// ps2_decode_if: scan-byte input and key-event/lock outputs of the PS/2 scan-code decoder
interface ps2_decode_if;
  logic       code_new;
  logic [7:0] new_code;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_pause;
  logic       bat_ok;
  logic       kbd_err;
  logic       Caps;
  logic       Num;
  logic       Scroll;
  modport master (
    output code_new, new_code,
    input  key_valid, key_code, key_ext, key_release, key_pause, bat_ok, kbd_err, Caps, Num, Scroll
  );
  modport slave (
    input  code_new, new_code,
    output key_valid, key_code, key_ext, key_release, key_pause, bat_ok, kbd_err, Caps, Num, Scroll
  );
endinterface

// File: rtl/ps2_decode.sv
// ps2_decode: folds PS/2 set-2 prefix sequences into key events and tracks lock states; PS2_DECODE_PAUSE_EN enables Pause decoding
module ps2_decode #(
  parameter int PREFIX_TIMEOUT = 65535
) (
  input logic       clk_decode,
  input logic       rst_decode,
  ps2_decode_if.slave bus
);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
`ifdef PS2_DECODE_PAUSE_EN
    EXT_BRK,
    PAUSE
`else
    EXT_BRK
`endif
  } state_t;
  state_t state, state_n;
  logic code_prev, acc, to_exp;
  logic [TW-1:0] to_cnt, to_n;
  logic [7:0] b, code_q, code_n;
  logic valid_q, valid_n, ext_q, ext_n, rel_q, rel_n, bat_q, bat_n, err_q, err_n;
  logic [2:0] lock_q, lock_n, held_q, held_n, hit;
  logic ev, ev_ext, ev_rel;
`ifdef PS2_DECODE_PAUSE_EN
  logic [2:0] pcnt_q, pcnt_n;
  logic pause_q, pause_n;
`endif
  assign b = bus.new_code;
  assign acc = bus.code_new & ~code_prev;
  assign to_exp = (state != IDLE) && (to_cnt == TW'(PREFIX_TIMEOUT));
  assign hit = {b == 8'h7E, b == 8'h77, b == 8'h58};
  always_comb begin
    state_n = state;
    to_n = (state == IDLE) ? '0 : to_cnt + 1'b1;
    ev = 1'b0;
    ev_ext = 1'b0;
    ev_rel = 1'b0;
    bat_n = 1'b0;
    err_n = 1'b0;
    lock_n = lock_q;
    held_n = held_q;
`ifdef PS2_DECODE_PAUSE_EN
    pcnt_n = pcnt_q;
    pause_n = 1'b0;
`endif
    if (acc) begin
      to_n = '0;
      case (state)
        IDLE: begin
          if (b == 8'hE0) state_n = EXT;
          else if (b == 8'hF0) state_n = BRK;
`ifdef PS2_DECODE_PAUSE_EN
          else if (b == 8'hE1) begin
            state_n = PAUSE;
            pcnt_n = '0;
          end
`endif
          else if (b == 8'hAA) begin
            bat_n = 1'b1;
            lock_n = '0;
            held_n = '0;
          end
          else if (b inside {8'h00, 8'hFC, 8'hFF}) err_n = 1'b1;
          else ev = !(b inside {8'hFA, 8'hFE, 8'hEE, 8'hE1});
        end
        EXT: begin
          state_n = (b == 8'hF0) ? EXT_BRK : IDLE;
          ev = !(b inside {8'hF0, 8'h12, 8'h59});
          ev_ext = 1'b1;
        end
        BRK: begin
          state_n = IDLE;
          ev = 1'b1;
          ev_rel = 1'b1;
        end
        EXT_BRK: begin
          state_n = IDLE;
          ev = !(b inside {8'h12, 8'h59});
          ev_ext = 1'b1;
          ev_rel = 1'b1;
        end
`ifdef PS2_DECODE_PAUSE_EN
        PAUSE: begin
          state_n = (pcnt_q == 3'd6) ? IDLE : PAUSE;
          pause_n = pcnt_q == 3'd6;
          pcnt_n = pcnt_q + 1'b1;
        end
`endif
        default: state_n = IDLE;
      endcase
    end else if (to_exp) begin
      state_n = IDLE;
      err_n = 1'b1;
      to_n = '0;
`ifdef PS2_DECODE_PAUSE_EN
      pcnt_n = '0;
`endif
    end
    if (ev && !ev_ext) begin
      lock_n = lock_n ^ (hit & ~held_q & {3{!ev_rel}});
      held_n = ev_rel ? (held_q & ~hit) : (held_q | hit);
    end
    valid_n = ev;
    code_n = ev ? b : code_q;
    ext_n = ev ? ev_ext : ext_q;
    rel_n = ev ? ev_rel : rel_q;
  end
  always_ff @(posedge clk_decode) begin
    if (rst_decode) begin
      state <= IDLE;
      code_prev <= 1'b0;
      to_cnt <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
      ext_q <= 1'b0;
      rel_q <= 1'b0;
      bat_q <= 1'b0;
      err_q <= 1'b0;
      lock_q <= '0;
      held_q <= '0;
`ifdef PS2_DECODE_PAUSE_EN
      pcnt_q <= '0;
      pause_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      code_prev <= bus.code_new;
      to_cnt <= to_n;
      code_q <= code_n;
      valid_q <= valid_n;
      ext_q <= ext_n;
      rel_q <= rel_n;
      bat_q <= bat_n;
      err_q <= err_n;
      lock_q <= lock_n;
      held_q <= held_n;
`ifdef PS2_DECODE_PAUSE_EN
      pcnt_q <= pcnt_n;
      pause_q <= pause_n;
`endif
    end
  end
  assign bus.key_valid = valid_q;
  assign bus.key_code = code_q;
  assign bus.key_ext = ext_q;
  assign bus.key_release = rel_q;
  assign bus.bat_ok = bat_q;
  assign bus.kbd_err = err_q;
  assign bus.Caps = lock_q[0];
  assign bus.Num = lock_q[1];
  assign bus.Scroll = lock_q[2];
`ifdef PS2_DECODE_PAUSE_EN
  assign bus.key_pause = pause_q;
`else
  assign bus.key_pause = 1'b0;
`endif
endmodule
